// File: rtl/rv32im_dmem_ctrl_pkg.sv
// Shared state, size and timeout codes for the data-memory controller.
// Optional misalignment trap is enabled with DMEM_MISALIGN_CHECK_EN.
`ifndef API_DATA_WIDTH
`define API_DATA_WIDTH 32
`endif
`ifndef API_ADDR_WIDTH
`define API_ADDR_WIDTH 32
`endif

package rv32im_dmem_ctrl_pkg;

  localparam logic [1:0] DMEM_ST_IDLE = 2'd0;
  localparam logic [1:0] DMEM_ST_REQ  = 2'd1;
  localparam logic [1:0] DMEM_ST_WAIT = 2'd2;
  localparam logic [1:0] DMEM_ST_RESP = 2'd3;

  localparam logic [1:0] DMEM_SIZE_B = 2'b00;
  localparam logic [1:0] DMEM_SIZE_H = 2'b01;
  localparam logic [1:0] DMEM_SIZE_W = 2'b10;

  localparam int DMEM_TIMEOUT_DEFAULT = 255;

  function automatic logic dmem_misaligned(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    return ((size == DMEM_SIZE_H) && lo[0]) ||
           ((size == DMEM_SIZE_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/rv32im_dmem_ctrl_align.sv
// Store lane steering, load byte enables and misalignment detect.
// Purely combinational; used by rv32im_dmem_ctrl at request acceptance.
module rv32im_dmem_align
  import rv32im_dmem_ctrl_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [3:0]  wmask,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        we,
  output logic [31:0] wdata_lane,
  output logic        misaligned
);

  assign we = |wmask;
  // Loads fetch the whole word; the LSU extracts the lane itself.
  assign be = we ? wmask : 4'hF;
  assign wdata_lane = wdata << {addr_lo, 3'b000};
  assign misaligned = dmem_misaligned(size, addr_lo);

endmodule

// File: rtl/rv32im_dmem_ctrl.sv
// Single-outstanding data-memory controller with stall, timeout and error.
// Define DMEM_MISALIGN_CHECK_EN to trap misaligned half/word accesses.
`ifndef API_DATA_WIDTH
`define API_DATA_WIDTH 32
`endif
`ifndef API_ADDR_WIDTH
`define API_ADDR_WIDTH 32
`endif

module rv32im_dmem_ctrl
  import rv32im_dmem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = `API_DATA_WIDTH,
  parameter int ADDR_WIDTH     = `API_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  lsu_en_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [3:0]            lsu_wmask_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  input  logic [1:0]            lsu_size_i,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  stall_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [3:0]            bus_be_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  input  logic                  bus_gnt_i,
  input  logic                  bus_rvalid_i,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i,
  input  logic                  bus_err_i
);

  localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic        err_q;
  logic        load;
  logic [3:0]  be;
  logic        we;
  logic [31:0] wdata_lane;
  logic        mis;
  logic        bad;

  rv32im_dmem_align u_align (
    .addr_lo    (lsu_addr_i[1:0]),
    .size       (lsu_size_i),
    .wmask      (lsu_wmask_i),
    .wdata      (lsu_wdata_i),
    .be         (be),
    .we         (we),
    .wdata_lane (wdata_lane),
    .misaligned (mis)
  );

`ifdef DMEM_MISALIGN_CHECK_EN
  assign bad = mis;
`else
  logic unused_mis;
  assign unused_mis = mis;
  assign bad = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state       <= DMEM_ST_IDLE;
      cnt         <= '0;
      err_q       <= 1'b0;
      load        <= 1'b0;
      bus_addr_o  <= '0;
      bus_be_o    <= '0;
      bus_we_o    <= 1'b0;
      bus_wdata_o <= '0;
      lsu_rdata_o <= '0;
    end else begin
      unique case (state)
        DMEM_ST_IDLE: begin
          if (lsu_en_i) begin
            bus_addr_o  <= {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
            bus_be_o    <= be;
            bus_we_o    <= we;
            bus_wdata_o <= wdata_lane;
            load        <= ~we;
            cnt         <= '0;
            err_q       <= bad;
            state       <= bad ? DMEM_ST_RESP : DMEM_ST_REQ;
          end
        end
        DMEM_ST_REQ: begin
          cnt <= cnt + 8'd1;
          if (cnt == LAST) begin
            err_q <= 1'b1;
            state <= DMEM_ST_RESP;
          end else if (bus_gnt_i) begin
            state <= DMEM_ST_WAIT;
          end
        end
        DMEM_ST_WAIT: begin
          cnt <= cnt + 8'd1;
          // A real response wins over a coincident timeout.
          if (bus_rvalid_i) begin
            err_q <= bus_err_i;
            if (load) lsu_rdata_o <= bus_rdata_i;
            state <= DMEM_ST_RESP;
          end else if (cnt == LAST) begin
            err_q <= 1'b1;
            state <= DMEM_ST_RESP;
          end
        end
        DMEM_ST_RESP: begin
          state <= DMEM_ST_IDLE;
        end
      endcase
    end
  end

  assign bus_req_o = (state == DMEM_ST_REQ);
  assign done_o    = (state == DMEM_ST_RESP);
  assign err_o     = done_o & err_q;
  assign stall_o   = ((state == DMEM_ST_IDLE) & lsu_en_i) |
                     (state == DMEM_ST_REQ) |
                     (state == DMEM_ST_WAIT);

endmodule
